apb_arbiter_rr_n: RTL and testbench

//  N-master to 1-slave APB arbiter; generalised successor of the 2-master arbiter on the core APB bus.

---
 rtl/apb_arb_pkg.sv | 20 ++
 rtl/apb_rr_picker.sv | 27 ++
 rtl/apb_arbiter_rr_n.sv | 156 +++++++++++++++
 tb/tb_apb_arbiter_rr_n.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the N-master APB arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  // k-th candidate of a round-robin search that starts just after ptr.
  function automatic int rr_index(input int ptr, input int k, input int n);
    return (ptr + 1 + k) % n;
  endfunction

endpackage

// File: rtl/apb_rr_picker.sv
// Combinational grant picker: round-robin from ptr+1, or lowest index first.
module apb_rr_picker
  import apb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  input  arb_mode_e              mode,
  output logic                   gnt_valid,
  output logic [IDX_W-1:0]       gnt_idx
);

  always_comb begin
    int cand;
    cand      = 0;
    gnt_valid = |req;
    gnt_idx   = '0;
    // Walk the search order backwards so the earliest hit is the last write.
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      cand = (mode == ARB_FIXED) ? k : rr_index(int'(ptr), k, NUM_MASTERS);
      if (req[IDX_W'(cand)]) gnt_idx = IDX_W'(cand);
    end
  end

endmodule

// File: rtl/apb_arbiter_rr_n.sv
// N-master to 1-slave APB arbiter with round-robin/fixed-priority grant,
// back-to-back transfers and an optional ACCESS-phase timeout.
module apb_arbiter_rr_n
  import apb_arb_pkg::*;
#(
  parameter int  ADDR_WIDTH     = 32,
  parameter int  DATA_WIDTH     = 32,
  parameter int  NUM_MASTERS    = 4,
  parameter int  ARB_MODE       = 0,
  parameter int  TIMEOUT_CYCLES = 0,
  localparam int STRB_WIDTH     = DATA_WIDTH / 8,
  localparam int IDX_W          = $clog2(NUM_MASTERS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            m_psel,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_paddr,
  input  logic [NUM_MASTERS*3-1:0]          m_pprot,
  input  logic [NUM_MASTERS-1:0]            m_pwrite,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_pwdata,
  input  logic [NUM_MASTERS*STRB_WIDTH-1:0] m_pstrb,
  output logic [NUM_MASTERS-1:0]            m_pready,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_prdata,
  output logic [NUM_MASTERS-1:0]            m_pslverr,
  output logic                              s_psel,
  output logic                              s_penable,
  output logic                              s_pwrite,
  output logic [ADDR_WIDTH-1:0]             s_paddr,
  output logic [2:0]                        s_pprot,
  output logic [DATA_WIDTH-1:0]             s_pwdata,
  output logic [STRB_WIDTH-1:0]             s_pstrb,
  input  logic                              s_pready,
  input  logic                              s_pslverr,
  input  logic [DATA_WIDTH-1:0]             s_prdata,
  output logic                              busy,
  output logic [IDX_W-1:0]                  grant_idx,
  output logic                              timeout_o
);

  localparam arb_mode_e MODE = (ARB_MODE == 1) ? ARB_FIXED : ARB_RR;
  localparam int TMR_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [TMR_W-1:0] TMO_LAST_V = TMR_W'(TMO_LAST);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [TMR_W-1:0]       timer_q, timer_d;

  logic                   pick_valid;
  logic [IDX_W-1:0]       pick_idx;
  logic [NUM_MASTERS-1:0] owner_oh;
  logic                   in_access, tmo_hit, xfer_done, abort, other_req;

  apb_rr_picker #(
    .NUM_MASTERS(NUM_MASTERS),
    .IDX_W      (IDX_W)
  ) u_picker (
    .req      (m_psel),
    .ptr      (rr_ptr_q),
    .mode     (MODE),
    .gnt_valid(pick_valid),
    .gnt_idx  (pick_idx)
  );

  assign owner_oh  = NUM_MASTERS'(1) << grant_q;
  assign in_access = (state_q == ACCESS);
  assign tmo_hit   = in_access && (TIMEOUT_CYCLES > 0) && (timer_q == TMO_LAST_V);
  assign xfer_done = in_access && (s_pready || tmo_hit);
  // A same-cycle s_pready beats expiry, so only a silent slave counts as an abort.
  assign abort     = tmo_hit && !s_pready;
  // The owner's own psel must not keep the bus busy back-to-back.
  assign other_req = |(m_psel & ~owner_oh);

  assign busy      = (state_q != IDLE);
  assign grant_idx = grant_q;
  assign timeout_o = abort;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    timer_d  = timer_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = SETUP;
          grant_d = pick_idx;
          timer_d = '0;
          if (MODE == ARB_RR) rr_ptr_d = pick_idx;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        timer_d = timer_q + 1'b1;
        if (xfer_done) begin
          timer_d = '0;
          if (other_req) begin
            state_d = SETUP;
            grant_d = pick_idx;
            if (MODE == ARB_RR) rr_ptr_d = pick_idx;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= IDX_W'(NUM_MASTERS - 1);
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      timer_q  <= timer_d;
    end
  end

  always_comb begin
    s_psel    = 1'b0;
    s_penable = 1'b0;
    s_pwrite  = 1'b0;
    s_paddr   = '0;
    s_pprot   = '0;
    s_pwdata  = '0;
    s_pstrb   = '0;
    if (state_q != IDLE) begin
      s_psel    = 1'b1;
      s_penable = in_access;
      s_pwrite  = m_pwrite[grant_q];
      s_paddr   = m_paddr[int'(grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
      s_pprot   = m_pprot[int'(grant_q)*3 +: 3];
      s_pwdata  = m_pwdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
      s_pstrb   = m_pstrb[int'(grant_q)*STRB_WIDTH +: STRB_WIDTH];
    end
  end

  // Responses reach only an owner that still holds psel; otherwise they are dropped.
  always_comb begin
    m_pready  = '0;
    m_pslverr = '0;
    m_prdata  = '0;
    if (in_access && m_psel[grant_q]) begin
      m_pready[grant_q]  = xfer_done;
      m_pslverr[grant_q] = abort | s_pslverr;
      m_prdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH] = abort ? '0 : s_prdata;
    end
  end

endmodule

// File: tb/tb_apb_arbiter_rr_n.sv
// Bench for apb_arbiter_rr_n: a round-robin/timeout instance and a fixed-priority
// instance share stimulus; a transaction-level model predicts every output each cycle.
module tb_apb_arbiter_rr_n;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int IW  = 2;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    m_psel, m_pwrite;
  logic [N*AW-1:0] m_paddr;
  logic [N*3-1:0]  m_pprot;
  logic [N*DW-1:0] m_pwdata;
  logic [N*SW-1:0] m_pstrb;
  logic            s_pready, s_pslverr;
  logic [DW-1:0]   s_prdata;

  logic [N-1:0]    o_pready [2];
  logic [N-1:0]    o_pslverr[2];
  logic [N*DW-1:0] o_prdata [2];
  logic            o_psel [2];
  logic            o_pen  [2];
  logic            o_pwr  [2];
  logic            o_busy [2];
  logic            o_tmo  [2];
  logic [AW-1:0]   o_paddr[2];
  logic [2:0]      o_pprot[2];
  logic [DW-1:0]   o_pwdata[2];
  logic [SW-1:0]   o_pstrb[2];
  logic [IW-1:0]   o_gnt  [2];

  apb_arbiter_rr_n #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_MASTERS(N),
                     .ARB_MODE(0), .TIMEOUT_CYCLES(TMO)) u_rr (
    .clk(clk), .rst(rst), .m_psel(m_psel), .m_paddr(m_paddr), .m_pprot(m_pprot),
    .m_pwrite(m_pwrite), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb),
    .m_pready(o_pready[0]), .m_prdata(o_prdata[0]), .m_pslverr(o_pslverr[0]),
    .s_psel(o_psel[0]), .s_penable(o_pen[0]), .s_pwrite(o_pwr[0]), .s_paddr(o_paddr[0]),
    .s_pprot(o_pprot[0]), .s_pwdata(o_pwdata[0]), .s_pstrb(o_pstrb[0]),
    .s_pready(s_pready), .s_pslverr(s_pslverr), .s_prdata(s_prdata),
    .busy(o_busy[0]), .grant_idx(o_gnt[0]), .timeout_o(o_tmo[0])
  );

  apb_arbiter_rr_n #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_MASTERS(N),
                     .ARB_MODE(1), .TIMEOUT_CYCLES(0)) u_fp (
    .clk(clk), .rst(rst), .m_psel(m_psel), .m_paddr(m_paddr), .m_pprot(m_pprot),
    .m_pwrite(m_pwrite), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb),
    .m_pready(o_pready[1]), .m_prdata(o_prdata[1]), .m_pslverr(o_pslverr[1]),
    .s_psel(o_psel[1]), .s_penable(o_pen[1]), .s_pwrite(o_pwr[1]), .s_paddr(o_paddr[1]),
    .s_pprot(o_pprot[1]), .s_pwdata(o_pwdata[1]), .s_pstrb(o_pstrb[1]),
    .s_pready(s_pready), .s_pslverr(s_pslverr), .s_prdata(s_prdata),
    .busy(o_busy[1]), .grant_idx(o_gnt[1]), .timeout_o(o_tmo[1])
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model: owner (-1 = bus free), cycles since grant (1 = setup phase,
  // n >= 2 = (n-1)th access cycle), last granted index and round-robin pointer.
  int own[2], age[2], gnt[2], ptr[2];
  int mode_of[2] = '{0, 1};
  int tmo_of [2] = '{TMO, 0};

  // Snapshot of outputs at the last sample point, for directed checks.
  logic            sn_psel[2], sn_pen[2], sn_busy[2], sn_tmo[2];
  logic [IW-1:0]   sn_gnt[2];
  logic [N-1:0]    sn_rdy[2], sn_err[2];
  logic [N*DW-1:0] sn_rd[2];
  logic [AW-1:0]   sn_addr[2];
  logic [DW-1:0]   sn_wdata[2];

  // Winner = requester with the smallest rank: its index (fixed) or its distance past ptr (RR).
  function automatic int pick(input int d, input logic [N-1:0] req);
    int best, best_key, key;
    best = -1;
    best_key = N;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        key = (mode_of[d] == 1) ? i : (i - ptr[d] - 1 + 2 * N) % N;
        if (key < best_key) begin
          best_key = key;
          best = i;
        end
      end
    end
    return best;
  endfunction

  task automatic give(input int d, input int p);
    own[d] = p;
    gnt[d] = p;
    age[d] = 1;
    if (mode_of[d] == 0) ptr[d] = p;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      own[d] = -1; age[d] = 0; gnt[d] = 0; ptr[d] = N - 1;
    end
  endtask

  task automatic model_step(input int d);
    int o, p;
    bit acc, hit, done, abrt, other;
    logic [N-1:0] e_rdy, e_err;
    logic [N*DW-1:0] e_rd;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [2:0] e_prot;
    logic [SW-1:0] e_strb;
    logic e_wr;
    o = own[d];
    acc  = (o >= 0) && (age[d] >= 2);
    hit  = acc && (tmo_of[d] > 0) && (age[d] - 1 == tmo_of[d]);
    done = acc && (s_pready || hit);
    abrt = hit && !s_pready;
    e_rdy = '0; e_err = '0; e_rd = '0;
    e_addr = '0; e_wdata = '0; e_prot = '0; e_strb = '0; e_wr = 1'b0;
    if (o >= 0) begin
      e_addr  = m_paddr[o*AW +: AW];
      e_wdata = m_pwdata[o*DW +: DW];
      e_prot  = m_pprot[o*3 +: 3];
      e_strb  = m_pstrb[o*SW +: SW];
      e_wr    = m_pwrite[o];
      if (acc && m_psel[o]) begin
        e_rdy[o] = done;
        e_err[o] = abrt ? 1'b1 : s_pslverr;
        e_rd[o*DW +: DW] = abrt ? '0 : s_prdata;
      end
    end
    check_eq($sformatf("d%0d busy", d),      o_busy[d],    o >= 0);
    check_eq($sformatf("d%0d grant_idx", d), o_gnt[d],     gnt[d]);
    check_eq($sformatf("d%0d s_psel", d),    o_psel[d],    o >= 0);
    check_eq($sformatf("d%0d s_penable", d), o_pen[d],     acc);
    check_eq($sformatf("d%0d s_pwrite", d),  o_pwr[d],     e_wr);
    check_eq($sformatf("d%0d s_paddr", d),   o_paddr[d],   e_addr);
    check_eq($sformatf("d%0d s_pprot", d),   o_pprot[d],   e_prot);
    check_eq($sformatf("d%0d s_pwdata", d),  o_pwdata[d],  e_wdata);
    check_eq($sformatf("d%0d s_pstrb", d),   o_pstrb[d],   e_strb);
    check_eq($sformatf("d%0d m_pready", d),  o_pready[d],  e_rdy);
    check_eq($sformatf("d%0d m_pslverr", d), o_pslverr[d], e_err);
    check_eq($sformatf("d%0d m_prdata", d),  o_prdata[d],  e_rd);
    check_eq($sformatf("d%0d timeout_o", d), o_tmo[d],     abrt);
    if (rst) begin
      own[d] = -1; age[d] = 0; gnt[d] = 0; ptr[d] = N - 1;
    end else if (o < 0) begin
      p = pick(d, m_psel);
      if (p >= 0) give(d, p);
    end else if (!acc) begin
      age[d] = 2;
    end else if (done) begin
      other = 1'b0;
      for (int i = 0; i < N; i++) if (i != o && m_psel[i]) other = 1'b1;
      if (other) give(d, pick(d, m_psel));
      else own[d] = -1;
    end else begin
      age[d] = age[d] + 1;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      sn_psel[d] = o_psel[d];   sn_pen[d] = o_pen[d];     sn_busy[d] = o_busy[d];
      sn_tmo[d] = o_tmo[d];     sn_gnt[d] = o_gnt[d];     sn_rdy[d] = o_pready[d];
      sn_err[d] = o_pslverr[d]; sn_rd[d] = o_prdata[d];   sn_addr[d] = o_paddr[d];
      sn_wdata[d] = o_pwdata[d];
      model_step(d);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seq[$];
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    int n_pen, n_tmo;
    bit saw3;
    rst = 1'b1;
    m_psel = '0; m_pwrite = '0; m_paddr = '0; m_pprot = '0; m_pwdata = '0; m_pstrb = '0;
    s_pready = 1'b0; s_pslverr = 1'b0; s_prdata = '0;
    @(posedge clk);
    #1;
    model_reset();
    cycle();
    rst = 1'b0;

    // All four masters request continuously: RR order 0,1,2,3,0 with no idle gap.
    m_psel = '1; s_pready = 1'b1;
    m_paddr = {32'h300, 32'h200, 32'h100, 32'h000};
    for (int c = 0; c < 10; c++) begin
      cycle();
      if (sn_psel[0] && !sn_pen[0]) seq.push_back(int'(sn_gnt[0]));
      if (c > 0) check_eq("rr back-to-back busy", sn_busy[0], 1'b1);
    end
    check_eq("rr grant count", seq.size(), 5);
    for (int k = 0; k < 5 && k < seq.size(); k++)
      check_eq($sformatf("rr grant order %0d", k), seq[k], exp_seq[k]);
    m_psel = '0;
    repeat (3) cycle();

    // Single write from master 2.
    m_paddr[2*AW +: AW] = 32'h40; m_pwdata[2*DW +: DW] = 32'hDEADBEEF;
    m_pwrite = 4'b0100; m_psel = 4'b0100; s_pready = 1'b1;
    cycle();
    check_eq("t1 idle s_psel", sn_psel[0], 1'b0);
    cycle();
    check_eq("t1 setup s_psel", sn_psel[0], 1'b1);
    check_eq("t1 setup s_penable", sn_pen[0], 1'b0);
    cycle();
    check_eq("t1 access s_penable", sn_pen[0], 1'b1);
    check_eq("t1 m_pready", sn_rdy[0], 4'b0100);
    check_eq("t1 grant_idx", sn_gnt[0], 2'd2);
    check_eq("t1 s_paddr", sn_addr[0], 32'h40);
    check_eq("t1 s_pwdata", sn_wdata[0], 32'hDEADBEEF);
    m_psel = '0;
    cycle();
    check_eq("t1 m_pready after", sn_rdy[0], 4'b0000);
    check_eq("t1 busy after", sn_busy[0], 1'b0);

    // Fixed priority: 1 and 3 request, only 1 wins until it drops.
    m_psel = 4'b1010;
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (sn_psel[1] && !sn_pen[1]) check_eq("fp grant while 1 requests", sn_gnt[1], 2'd1);
    end
    m_psel = 4'b1000;
    saw3 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cycle();
      if (sn_psel[1] && !sn_pen[1] && sn_gnt[1] == 2'd3) saw3 = 1'b1;
    end
    check_eq("fp master 3 granted after drop", saw3, 1'b1);
    m_psel = '0;
    repeat (3) cycle();

    // Timeout: slave never ready.
    m_psel = 4'b0001; s_pready = 1'b0; n_pen = 0; n_tmo = 0;
    for (int c = 0; c < 10; c++) begin
      cycle();
      n_pen += int'(sn_pen[0]);
      n_tmo += int'(sn_tmo[0]);
    end
    check_eq("tmo abort m_pready", sn_rdy[0], 4'b0001);
    check_eq("tmo abort m_pslverr", sn_err[0], 4'b0001);
    check_eq("tmo abort m_prdata", sn_rd[0], '0);
    m_psel = '0; s_pready = 1'b1;
    cycle();
    n_tmo += int'(sn_tmo[0]);
    check_eq("tmo s_psel after abort", sn_psel[0], 1'b0);
    check_eq("tmo late pready ignored", sn_rdy[0], 4'b0000);
    s_pready = 1'b0;
    repeat (2) begin
      cycle();
      n_tmo += int'(sn_tmo[0]);
    end
    check_eq("tmo access cycles", n_pen, 8);
    check_eq("tmo pulse count", n_tmo, 1);
    s_pready = 1'b1;
    repeat (2) cycle();

    // Read by master 1; only its prdata slice carries the slave data.
    m_psel = 4'b0010; m_pwrite = '0; s_prdata = 32'h12345678; s_pslverr = 1'b0; s_pready = 1'b1;
    repeat (3) cycle();
    check_eq("rd m_prdata", sn_rd[0], 128'h12345678 << 32);
    check_eq("rd m_pready", sn_rdy[0], 4'b0010);
    m_psel = '0;
    repeat (2) cycle();

    // Reset during ACCESS, then master 0 wins first.
    m_psel = 4'b0100; s_pready = 1'b0;
    repeat (2) cycle();
    rst = 1'b1;
    cycle();
    check_eq("rst in access s_penable", sn_pen[0], 1'b1);
    rst = 1'b0; m_psel = 4'b0101;
    cycle();
    check_eq("rst s_psel", sn_psel[0], 1'b0);
    check_eq("rst busy", sn_busy[0], 1'b0);
    check_eq("rst grant_idx", sn_gnt[0], 2'd0);
    cycle();
    check_eq("rst first grant", sn_gnt[0], 2'd0);
    check_eq("rst setup s_psel", sn_psel[0], 1'b1);
    m_psel = '0; s_pready = 1'b1;
    repeat (3) cycle();

    // Randomized traffic with slow-slave windows to provoke timeouts.
    for (int c = 0; c < 2000 && failures < 20; c++) begin
      m_psel    = N'($urandom) & N'($urandom | $urandom);
      m_pwrite  = N'($urandom);
      m_paddr   = {$urandom, $urandom, $urandom, $urandom};
      m_pwdata  = {$urandom, $urandom, $urandom, $urandom};
      m_pprot   = 12'($urandom);
      m_pstrb   = 16'($urandom);
      s_pready  = ((c / 150) % 2 == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
      s_pslverr = ($urandom_range(0, 3) == 0);
      s_prdata  = $urandom;
      rst       = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
